// File: rtl/svi_arb_pkg.sv
// Shared types and elaboration helpers for the SVI drive arbiter.
package svi_arb_pkg;

   // Arbiter phases: free, one owner driving, one-cycle dead turnaround.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/svi_drive_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick
   import svi_arb_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_any,
   output logic [IDX_W-1:0] o_idx
);

   int sum;
   int lane;

   // Scan offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      sum   = 0;
      lane  = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         sum  = int'(i_ptr) + i;
         lane = (sum >= N_REQ) ? (sum - N_REQ) : sum;
         if (i_req[lane]) begin
            o_any = 1'b1;
            o_idx = IDX_W'(lane);
         end else begin
            o_any = o_any;
            o_idx = o_idx;
         end
      end
   end

endmodule

// File: rtl/svi_drive_arbiter.sv
// Round-robin owner arbitration for one shared SVI member with bounded
// hold time and a one-cycle dead turnaround between owners.
module svi_drive_arbiter
   import svi_arb_pkg::*;
#(
   parameter  int N_REQ    = 2,
   parameter  int WIDTH    = 1,
   parameter  int MAX_HOLD = 8,
   localparam int IDX_W    = idx_width(N_REQ),
   localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
   input  logic                   i_sclk,
   input  logic                   i_srst_n,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*WIDTH-1:0] i_data,
   output logic [N_REQ-1:0]       o_gnt,
   output logic [IDX_W-1:0]       o_gnt_idx,
   output logic                   o_valid,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_busy
);

   if (N_REQ < 2) begin : g_bad_n_req
      $error("svi_drive_arbiter: N_REQ must be >= 2");
   end
   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("svi_drive_arbiter: MAX_HOLD must be >= 1");
   end

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  owner_nxt;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  ptr_nxt;
   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] hold_nxt;
   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;

   // The pointer already points past the last owner while in RELEASE,
   // so one picker serves both IDLE and RELEASE arbitration.
   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req (i_req),
      .i_ptr (ptr),
      .o_any (pick_any),
      .o_idx (pick_idx)
   );

   // State, owner, pointer and hold counter registers with synchronous reset.
   always_ff @(posedge i_sclk) begin
      if (!i_srst_n) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
         hold  <= hold_nxt;
      end
   end

   // Next-state logic: arbitrate when free, bound ownership, advance pointer.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      hold_nxt  = hold;
      case (state)
         IDLE, RELEASE: begin
            hold_nxt = '0;
            if (pick_any) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
            end else begin
               state_nxt = IDLE;
            end
         end
         GRANT: begin
            if (!i_req[owner] || (hold == HOLD_W'(MAX_HOLD - 1))) begin
               state_nxt = RELEASE;
               hold_nxt  = '0;
               ptr_nxt   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
            end else begin
               hold_nxt  = hold + HOLD_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            owner_nxt = '0;
            ptr_nxt   = '0;
            hold_nxt  = '0;
         end
      endcase
   end

   // Outputs decoded from registered state; data lane muxed only while owned.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_data    = '0;
      o_valid   = (state == GRANT);
      o_busy    = (state != IDLE);
      if (state == GRANT) begin
         o_gnt[owner] = 1'b1;
         o_gnt_idx    = owner;
         o_data       = i_data[int'(owner)*WIDTH +: WIDTH];
      end else begin
         o_gnt     = '0;
         o_gnt_idx = '0;
         o_data    = '0;
      end
   end

endmodule

// File: tb/tb_svi_drive_arbiter.sv
// Directed self-checking bench for svi_drive_arbiter (N_REQ=2/MAX_HOLD=8
// and N_REQ=3/MAX_HOLD=1 instances).
module tb_svi_drive_arbiter;

   logic       clk = 1'b0;
   logic       srst_n;
   logic [1:0] req;
   logic [1:0] data;
   logic [1:0] gnt;
   logic [0:0] gnt_idx;
   logic       valid;
   logic [0:0] dout;
   logic       busy;

   logic        srst3_n;
   logic [2:0]  req3;
   logic [11:0] data3;
   logic [2:0]  gnt3;
   logic [1:0]  gnt3_idx;
   logic        valid3;
   logic [3:0]  dout3;
   logic        busy3;

   int checks   = 0;
   int failures = 0;
   bit mon_on   = 1'b0;
   int run_len  = 0;

   always #5 clk = ~clk;

   svi_drive_arbiter #(.N_REQ(2), .WIDTH(1), .MAX_HOLD(8)) dut (
      .i_sclk(clk), .i_srst_n(srst_n), .i_req(req), .i_data(data),
      .o_gnt(gnt), .o_gnt_idx(gnt_idx), .o_valid(valid), .o_data(dout), .o_busy(busy)
   );

   svi_drive_arbiter #(.N_REQ(3), .WIDTH(4), .MAX_HOLD(1)) dut3 (
      .i_sclk(clk), .i_srst_n(srst3_n), .i_req(req3), .i_data(data3),
      .o_gnt(gnt3), .o_gnt_idx(gnt3_idx), .o_valid(valid3), .o_data(dout3), .o_busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Invariants on the two-requester instance, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_on) begin
         run_len = valid ? run_len + 1 : 0;
         chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
         chk("inv_valid_or", 32'(valid), 32'(|gnt));
         chk("inv_run_len", 32'(run_len <= 8), 32'd1);
         if (valid) chk("inv_idx", 32'(gnt), 32'(2'b01 << gnt_idx));
         chk("inv3_onehot0", 32'($onehot0(gnt3)), 32'd1);
      end
   end

   initial begin
      int p;
      srst_n  = 1'b0;
      req     = 2'b11;
      data    = 2'b10;
      srst3_n = 1'b0;
      req3    = 3'b000;
      data3   = 12'h000;

      // Reset held with both requests active.
      step();
      step();
      mon_on = 1'b1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(dout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_idx", 32'(gnt_idx), 32'd0);
      srst_n = 1'b1;
      #1;
      chk("post_rst_idle_busy", 32'(busy), 32'd0);

      // First grant goes to requester 0 (pointer 0).
      step();
      chk("first_gnt", 32'(gnt), 32'd1);
      chk("first_data", 32'(dout), 32'd0);

      // Both requesting: 8x01, 00, 8x10, 00, repeating.
      for (int c = 1; c < 36; c++) begin
         step();
         p = c % 18;
         if (p < 8) begin
            chk("rr_gnt0", 32'(gnt), 32'd1);
            chk("rr_data0", 32'(dout), 32'd0);
         end else if (p == 8 || p == 17) begin
            chk("rr_dead_gnt", 32'(gnt), 32'd0);
            chk("rr_dead_busy", 32'(busy), 32'd1);
            chk("rr_dead_data", 32'(dout), 32'd0);
         end else begin
            chk("rr_gnt1", 32'(gnt), 32'd2);
            chk("rr_data1", 32'(dout), 32'd1);
            chk("rr_idx1", 32'(gnt_idx), 32'd1);
         end
      end

      // Lone requester 1: 8x10, 00, 8x10, busy throughout.
      req = 2'b10;
      for (int c = 0; c < 17; c++) begin
         step();
         p = c % 9;
         chk("lone_busy", 32'(busy), 32'd1);
         if (p < 8) chk("lone_gnt", 32'(gnt), 32'd2);
         else       chk("lone_dead", 32'(gnt), 32'd0);
      end

      // Drain to IDLE.
      req = 2'b00;
      step();
      chk("drain_release_busy", 32'(busy), 32'd1);
      step();
      chk("drain_idle_busy", 32'(busy), 32'd0);

      // Requester 0 pulses for three sampled cycles.
      req = 2'b01;
      step();
      chk("pulse_gnt_c1", 32'(gnt), 32'd1);
      step();
      chk("pulse_gnt_c2", 32'(gnt), 32'd1);
      step();
      chk("pulse_gnt_c3", 32'(gnt), 32'd1);
      req = 2'b00;
      step();
      chk("pulse_release_gnt", 32'(gnt), 32'd0);
      chk("pulse_release_busy", 32'(busy), 32'd1);
      step();
      chk("pulse_idle_busy", 32'(busy), 32'd0);

      // Pointer is 1: owner 1 granted, then reset on its 4th grant cycle.
      req = 2'b11;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("pre_rst_gnt1", 32'(gnt), 32'd2);
      end
      srst_n = 1'b0;
      step();
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_data", 32'(dout), 32'd0);
      srst_n = 1'b1;
      step();
      chk("after_rst_gnt0", 32'(gnt), 32'd1);
      chk("after_rst_idx0", 32'(gnt_idx), 32'd0);
      data = 2'b01;
      #1;
      chk("after_rst_data_lane0", 32'(dout), 32'd1);

      // Three requesters, MAX_HOLD=1, requests 101.
      req3    = 3'b101;
      data3   = 12'hCBA;
      srst3_n = 1'b1;
      step();
      chk("n3_gnt_a", 32'(gnt3), 32'd1);
      chk("n3_data_a", 32'(dout3), 32'hA);
      step();
      chk("n3_dead_a", 32'(gnt3), 32'd0);
      chk("n3_dead_busy", 32'(busy3), 32'd1);
      step();
      chk("n3_gnt_c", 32'(gnt3), 32'd4);
      chk("n3_idx_c", 32'(gnt3_idx), 32'd2);
      chk("n3_data_c", 32'(dout3), 32'hC);
      step();
      chk("n3_dead_b", 32'(gnt3), 32'd0);
      chk("n3_dead_data", 32'(dout3), 32'd0);
      step();
      chk("n3_wrap_gnt", 32'(gnt3), 32'd1);
      chk("n3_wrap_idx", 32'(gnt3_idx), 32'd0);

      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
